// File: rtl/phase_clk_gen_pkg.sv
// rtl/phase_clk_gen_pkg.sv - shared types and constants for the quadrature clock generator
//
// Purpose: FSM state encoding, phase constants and the phase-to-output decode
// shared by phase_clk_gen and phase_clk_gen_cnt.
// Ports: none (package).
// Optional feature macro used elsewhere in the bundle: PHASE_CLK_GEN_STATUS_EN.

package phase_clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [1:0] PH_000 = 2'd0;
  localparam logic [1:0] PH_090 = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // Width of the settle period counter; holds LOCK_PERIODS values up to 255.
  localparam int LOCK_CNT_W = 8;

  // Output levels for a given quarter: {p270, p180, p090, p000}.
  // Each output is high for two consecutive quarters, giving 50% duty.
  function automatic logic [3:0] phase_decode(input logic [1:0] ph);
    logic [3:0] lv;
    lv = 4'b0000;
    case (ph)
      PH_000:  lv = 4'b1001;
      PH_090:  lv = 4'b0011;
      PH_180:  lv = 4'b0110;
      PH_270:  lv = 4'b1100;
      default: lv = 4'b0000;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/phase_clk_gen_cnt.sv
// rtl/phase_clk_gen_cnt.sv - quarter and phase counters with period-boundary strobe
//
// Purpose: counts clk cycles inside a quarter (qcnt, 0..div_q) and quarters
// inside a period (ph, 0..3). While run is low both counters are held at zero.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - advance counters this cycle; low clears them
//   div_q       - latched quarter divisor, quarter length is div_q+1 cycles
//   ph_nxt      - phase value that ph takes at the coming edge
//   boundary    - last cycle of a period (ph=3 and qcnt at its last count)

module phase_clk_gen_cnt
  import phase_clk_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic [1:0]       ph_nxt,
  output logic             boundary
);

  logic [DIV_W-1:0] qcnt;
  logic [DIV_W-1:0] qcnt_nxt;
  logic [1:0]       ph;
  logic             q_last;

  // qcnt shares the divisor width, so div_q = all-ones is a quarter of
  // 2^DIV_W cycles without needing an extra counter bit.
  assign q_last   = (qcnt == div_q);
  assign boundary = run && (ph == PH_270) && q_last;

  always_comb begin
    qcnt_nxt = qcnt;
    ph_nxt   = ph;
    if (!run) begin
      qcnt_nxt = '0;
      ph_nxt   = PH_000;
    end else if (q_last) begin
      qcnt_nxt = '0;
      ph_nxt   = ph + 2'd1;
    end else begin
      qcnt_nxt = qcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
      ph   <= PH_000;
    end else begin
      qcnt <= qcnt_nxt;
      ph   <= ph_nxt;
    end
  end

endmodule

// File: rtl/phase_clk_gen.sv
// rtl/phase_clk_gen.sv - four-phase quadrature clock generator with lock FSM
//
// Purpose: divides clk into four 50%-duty clocks 90 degrees apart, period
// 4*(div+1) clk cycles. locked rises after LOCK_PERIODS whole periods at a
// stable divisor; div is only looked at on period boundaries. Dropping enable
// lets the running period finish before all outputs go low.
// Optional macro: PHASE_CLK_GEN_STATUS_EN adds lock_loss_cnt.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   enable           - level request to run
//   div              - quarter divisor, quarter = div+1 clk cycles
//   clk_p000..p270   - registered quadrature clocks
//   locked           - outputs stable at the latched ratio
//   lock_loss_cnt    - (macro only) saturating count of LOCKED->SETTLE exits

module phase_clk_gen
  import phase_clk_gen_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int LOCK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             clk_p000,
  output logic             clk_p090,
  output logic             clk_p180,
  output logic             clk_p270,
  output logic             locked
`ifdef PHASE_CLK_GEN_STATUS_EN
  ,
  output logic [7:0]       lock_loss_cnt
`endif
);

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_q, div_q_nxt;
  logic [LOCK_CNT_W-1:0] pcnt, pcnt_nxt;
  logic                  locked_nxt;
  logic [3:0]            clk_q, clk_nxt;
  logic [1:0]            ph_nxt;
  logic                  boundary;
  logic                  run;

  // Counters are held at zero in IDLE, so the first SETTLE cycle is ph=0.
  assign run = (state != ST_IDLE);

  phase_clk_gen_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .div_q    (div_q),
    .ph_nxt   (ph_nxt),
    .boundary (boundary)
  );

  always_comb begin
    state_nxt  = state;
    div_q_nxt  = div_q;
    pcnt_nxt   = pcnt;
    locked_nxt = locked;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_SETTLE;
          div_q_nxt = div;
          pcnt_nxt  = '0;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_nxt = ST_DRAIN;
        end else if (boundary) begin
          if (div != div_q) begin
            // Ratio moved while settling: restart the stability count.
            div_q_nxt = div;
            pcnt_nxt  = '0;
          end else if (pcnt == LOCK_CNT_W'(LOCK_PERIODS - 1)) begin
            state_nxt  = ST_LOCKED;
            locked_nxt = 1'b1;
            pcnt_nxt   = '0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (!enable) begin
          state_nxt  = ST_DRAIN;
          locked_nxt = 1'b0;
        end else if (boundary && (div != div_q)) begin
          state_nxt  = ST_SETTLE;
          locked_nxt = 1'b0;
          div_q_nxt  = div;
          pcnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        // enable is deliberately not examined here; only a full period
        // end returns to IDLE, which keeps the last high pulse full width.
        if (boundary) begin
          state_nxt = ST_IDLE;
          pcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        locked_nxt = 1'b0;
      end
    endcase

    // Outputs are loaded on the same edge as ph so they never glitch.
    if (state_nxt == ST_IDLE) begin
      clk_nxt = 4'b0000;
    end else begin
      clk_nxt = phase_decode(ph_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      div_q  <= '0;
      pcnt   <= '0;
      locked <= 1'b0;
      clk_q  <= 4'b0000;
    end else begin
      state  <= state_nxt;
      div_q  <= div_q_nxt;
      pcnt   <= pcnt_nxt;
      locked <= locked_nxt;
      clk_q  <= clk_nxt;
    end
  end

  assign clk_p000 = clk_q[0];
  assign clk_p090 = clk_q[1];
  assign clk_p180 = clk_q[2];
  assign clk_p270 = clk_q[3];

`ifdef PHASE_CLK_GEN_STATUS_EN
  logic loss_evt;

  assign loss_evt = (state == ST_LOCKED) && (state_nxt == ST_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_evt && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phase_clk_gen.sv
// tb/tb_phase_clk_gen.sv - self-checking bench for phase_clk_gen

module tb_phase_clk_gen;

  localparam int DIV_W        = 8;
  localparam int LOCK_PERIODS = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [DIV_W-1:0] div;
  logic             clk_p000, clk_p090, clk_p180, clk_p270;
  logic             locked;
`ifdef PHASE_CLK_GEN_STATUS_EN
  logic [7:0]       lock_loss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 settle, 2 locked, 3 drain.
  // m_pos is the cycle position inside the current period (0..4Q-1).
  int m_mode, m_pos, m_q, m_per, m_loss;
  bit m_locked;

  phase_clk_gen #(
    .DIV_W        (DIV_W),
    .LOCK_PERIODS (LOCK_PERIODS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div      (div),
    .clk_p000 (clk_p000),
    .clk_p090 (clk_p090),
    .clk_p180 (clk_p180),
    .clk_p270 (clk_p270),
    .locked   (locked)
`ifdef PHASE_CLK_GEN_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_q = 1; m_per = 0; m_loss = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit en, input int dv);
    int q_new;
    int old_mode;
    bit eop;
    q_new    = dv + 1;
    old_mode = m_mode;
    eop      = (m_mode != 0) && (m_pos == 4 * m_q - 1);
    case (m_mode)
      0: if (en) begin m_mode = 1; m_q = q_new; m_per = 0; end
      1: begin
        if (!en) m_mode = 3;
        else if (eop) begin
          if (q_new != m_q) begin m_q = q_new; m_per = 0; end
          else begin
            m_per++;
            if (m_per == LOCK_PERIODS) begin m_mode = 2; m_locked = 1; m_per = 0; end
          end
        end
      end
      2: begin
        if (!en) begin m_mode = 3; m_locked = 0; end
        else if (eop && q_new != m_q) begin
          m_mode = 1; m_locked = 0; m_q = q_new; m_per = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      default: if (eop) m_mode = 0;
    endcase
    if (old_mode == 0 || m_mode == 0) m_pos = 0;
    else m_pos = eop ? 0 : m_pos + 1;
  endtask

  function automatic logic [4:0] model_expect();
    int qt;
    logic [4:0] e;
    e = {m_locked, 4'b0000};
    if (m_mode != 0) begin
      qt   = m_pos / m_q;
      e[0] = (qt == 0 || qt == 1);
      e[1] = (qt == 1 || qt == 2);
      e[2] = (qt == 2 || qt == 3);
      e[3] = (qt == 3 || qt == 0);
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {locked, clk_p270, clk_p180, clk_p090, clk_p000};
    exp = model_expect();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, exp);
    end
`ifdef PHASE_CLK_GEN_STATUS_EN
    total++;
    assert (lock_loss_cnt === 8'(m_loss)) else begin
      bad++;
      $error("FAIL %s_loss t=%0t obs=%0d exp=%0d", tag, $time, lock_loss_cnt, m_loss);
    end
`endif
  endtask

  // One clk edge: model follows the inputs the DUT samples, compare at negedge.
  task automatic tick(input string tag = "tick");
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(enable, int'(div));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic wait_locked(input logic target, input int max, output int n);
    n = 0;
    while (locked !== target && n < max) begin
      tick("wait_lock");
      n++;
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int r;
    logic [4:0] snap;

    model_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    div    = '0;
    repeat (2) tick("reset");
    rst_n = 1'b1;
    repeat (3) tick("idle_no_enable");

    // div=1: first SETTLE cycle drives p000/p270, lock after 32 cycles.
    div    = 8'd1;
    enable = 1'b1;
    tick("first_edge");
    snap = {clk_p270, clk_p180, clk_p090, clk_p000};
    check_int("first_phase", int'(snap), 9);
    wait_locked(1'b1, 100, n);
    check_int("lock_cycle_div1", n + 1, 33);

    // Ratio change mid-period: holds until boundary, then relock at Q=4.
    repeat (3) tick("locked_div1");
    div = 8'd3;
    wait_locked(1'b0, 50, n);
    check_int("unlock_at_boundary", n, 5);
    wait_locked(1'b1, 200, n);
    check_int("relock_div3", n, 64);

    // Drop enable in ph=1; a DRAIN enable pulse must be ignored.
    repeat (4) tick("locked_div3");
    enable = 1'b0;
    repeat (3) tick("drain");
    enable = 1'b1;
    tick("drain_pulse");
    enable = 1'b0;
    n = 0;
    while ({clk_p270, clk_p180, clk_p090, clk_p000} !== 4'b0000 && n < 50) begin
      tick("drain_end");
      n++;
    end
    check_int("drain_len", n, 8);
    repeat (5) tick("idle_after_drain");

    // div=0: period of 4, lock after 16 SETTLE cycles.
    div    = 8'd0;
    enable = 1'b1;
    wait_locked(1'b1, 100, n);
    check_int("lock_cycle_div0", n, 17);
    repeat (6) tick("locked_div0");

    // Asynchronous reset while LOCKED.
    #1 rst_n = 1'b0;
    #1;
    snap = {locked, clk_p270, clk_p180, clk_p090, clk_p000};
    check_int("async_reset", int'(snap), 0);
    model_reset();
    enable = 1'b0;
    repeat (2) tick("in_reset");
    rst_n = 1'b1;
    repeat (4) tick("post_reset_idle");

    // Randomized run against the model.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) enable = ~enable;
      r = int'($urandom_range(0, 99));
      if (r < 3) div = 8'($urandom_range(0, 4));
      tick("random");
    end

    // Largest divisor: quarter of 256 cycles.
    enable = 1'b0;
    n = 0;
    while (m_mode != 0 && n < 2000) begin
      tick("to_idle");
      n++;
    end
    check_int("reach_idle", m_mode, 0);
    div    = 8'hFF;
    enable = 1'b1;
    wait_locked(1'b1, 5000, n);
    check_int("lock_cycle_divmax", n, 4097);

`ifdef PHASE_CLK_GEN_STATUS_EN
    div = 8'd0;
    for (int i = 0; i < 300; i++) begin
      wait_locked(1'b1, 200, n);
      div = (div == 8'd0) ? 8'd1 : 8'd0;
      wait_locked(1'b0, 2000, n);
    end
    check_int("loss_saturate", int'(lock_loss_cnt), 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
